// File: rtl/de1_soc_pkg.sv
// Shared widths, 7-segment type and active-low digit patterns for the DE1-SoC demo wrapper.
package de1_soc_pkg;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int SW_W  = 10;

  typedef logic [6:0] seg_t;

  // Bit order {g,f,e,d,c,b,a}; a segment lights when its bit is 0.
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import de1_soc_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  // Nibble lookup into the digit table
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/de1_soc_wrapper.sv
// DE1-SoC top: reset/button/switch conditioning, 16-bit load/accumulate datapath,
// event counter, and registered LED / 7-segment outputs.
module de1_soc_wrapper #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  import de1_soc_pkg::*;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_btn_meta;
  logic [1:0]       r_btn_sync;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic [1:0]       w_btn_db;
  logic [1:0]       r_btn_db_prev;
  logic [1:0]       w_press;
  logic [ACC_W-1:0] w_sw_ext;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_evt_cnt;
  seg_t             w_seg [4];

  // Reset: asserts asynchronously, releases two clocks after KEY[2] goes high
  always_ff @(posedge CLOCK_50 or negedge KEY[2]) begin
    if (!KEY[2]) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchronisers for the (inverted) buttons and the switches
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_btn_meta <= 2'b00;
      r_btn_sync <= 2'b00;
      r_sw_meta  <= {SW_W{1'b0}};
      r_sw_sync  <= {SW_W{1'b0}};
    end else begin
      r_btn_meta <= ~KEY[1:0];
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // Level follows the synced input only after it disagrees for DEBOUNCE_CYCLES straight clocks
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [DB_W-1:0] r_cnt;
    logic            r_level;

    // Per-button debounce counter and accepted level
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_cnt   <= {DB_W{1'b0}};
        r_level <= 1'b0;
      end else if (r_btn_sync[g] != r_level) begin
        if (r_cnt == DB_LAST) begin
          r_cnt   <= {DB_W{1'b0}};
          r_level <= r_btn_sync[g];
        end else begin
          r_cnt   <= r_cnt + DB_ONE;
        end
      end else begin
        r_cnt <= {DB_W{1'b0}};
      end
    end

    assign w_btn_db[g] = r_level;
  end

  assign w_press  = w_btn_db & ~r_btn_db_prev;
  assign w_sw_ext = {{(ACC_W - SW_W){1'b0}}, r_sw_sync};

  // Datapath: load wins over accumulate; any press bumps the event counter once
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_btn_db_prev <= 2'b00;
      r_acc         <= {ACC_W{1'b0}};
      r_evt_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_btn_db_prev <= w_btn_db;
      if (w_press[0]) begin
        r_acc <= w_sw_ext;
      end else if (w_press[1]) begin
        r_acc <= r_acc + w_sw_ext;
      end else begin
        r_acc <= r_acc;
      end
      if (|w_press) begin
        r_evt_cnt <= r_evt_cnt + CNT_ONE;
      end else begin
        r_evt_cnt <= r_evt_cnt;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_hex
    hex_to_seg7 u_hex_to_seg7 (
      .i_nibble (r_acc[4*k +: 4]),
      .o_seg    (w_seg[k])
    );
  end

  // Registered board outputs
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      LEDR <= 10'h000;
      HEX0 <= SEG_0;
      HEX1 <= SEG_0;
      HEX2 <= SEG_0;
      HEX3 <= SEG_0;
    end else begin
      LEDR <= {w_btn_db[1], w_btn_db[0], r_evt_cnt};
      HEX0 <= w_seg[0];
      HEX1 <= w_seg[1];
      HEX2 <= w_seg[2];
      HEX3 <= w_seg[3];
    end
  end

endmodule

// File: tb/tb_de1_soc_wrapper.sv
// Directed plus randomized bench for de1_soc_wrapper against an arithmetic model of ACC and the event count.
module tb_de1_soc_wrapper;

  localparam int DEB = 16;

  logic       clk;
  logic [2:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  int m_cnt  = 0;

  de1_soc_wrapper #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50 (clk),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v & 15)
      0:  return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4:  return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8:  return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] hex_of(input int v);
    return {seg_of(v >> 12), seg_of(v >> 8), seg_of(v >> 4), seg_of(v)};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_hex"}, {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hex_of(m_acc)});
    check({tag, "_ledr"}, {22'h0, LEDR}, {22'h0, 2'b00, 8'(m_cnt)});
  endtask

  // Press with the given buttons for 'hold' clocks, release, and settle; the model
  // only acts on holds long enough to pass the debouncer.
  task automatic press(input bit b0, input bit b1, input int hold);
    @(negedge clk);
    KEY[0] = ~b0;
    KEY[1] = ~b1;
    wait_clk(hold);
    KEY[1:0] = 2'b11;
    wait_clk(30);
    if (hold >= DEB + 4 && (b0 || b1)) begin
      if (b0) m_acc = int'(SW);
      else    m_acc = (m_acc + int'(SW)) % 65536;
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    KEY[2] = 1'b0;
    wait_clk(3);
    KEY[2] = 1'b1;
    wait_clk(5);
    m_acc = 0;
    m_cnt = 0;
  endtask

  task automatic set_sw(input int v);
    @(negedge clk);
    SW = 10'(v);
    wait_clk(4);
  endtask

  initial begin
    int op, hold;
    KEY = 3'b011;
    SW  = 10'h000;
    wait_clk(5);
    check("reset_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 28'h8102040});
    check("reset_ledr", {22'h0, LEDR}, 32'h0);
    KEY[2] = 1'b1;
    wait_clk(500);
    check("idle_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 28'h8102040});
    check("idle_ledr", {22'h0, LEDR}, 32'h0);

    set_sw(1);
    press(1'b1, 1'b0, 50);
    press(1'b0, 1'b1, 50);
    check("sw1_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h24});
    check("sw1_cnt", {24'h0, LEDR[7:0]}, 32'd2);
    check_model("sw1");

    set_sw(15);
    press(1'b1, 1'b0, 40);
    press(1'b0, 1'b1, 40);
    check("sw15_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h79, 7'h06});
    set_sw(12);
    press(1'b1, 1'b0, 40);
    press(1'b0, 1'b1, 40);
    check("sw12_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h79, 7'h00});
    check_model("sw12");

    set_sw(9);
    press(1'b1, 1'b0, 10);
    check("glitch_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h79, 7'h00});
    check_model("glitch");

    set_sw(7);
    press(1'b1, 1'b0, 40);
    set_sw(5);
    press(1'b1, 1'b1, 40);
    check("simul_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h12});
    check_model("simul");

    // Latency: HEX must still show the old value 15 clocks after the fall and the new one by 21
    set_sw(10'h2A3);
    @(negedge clk);
    KEY[0] = 1'b0;
    wait_clk(15);
    check("lat_early", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hex_of(m_acc)});
    wait_clk(6);
    m_acc = 10'h2A3;
    m_cnt = (m_cnt + 1) % 256;
    check("lat_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hex_of(m_acc)});
    check("lat_led8", {31'h0, LEDR[8]}, 32'd1);
    KEY[0] = 1'b1;
    wait_clk(30);
    check_model("lat_release");

    // Reset while button 0 held: cleared at once, then accepted again after full debounce
    set_sw(10'h155);
    @(negedge clk);
    KEY[0] = 1'b0;
    wait_clk(40);
    #3 KEY[2] = 1'b0;
    #3;
    check("midrst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 28'h8102040});
    check("midrst_ledr", {22'h0, LEDR}, 32'h0);
    wait_clk(3);
    KEY[2] = 1'b1;
    m_acc = 0;
    m_cnt = 0;
    wait_clk(8);
    check_model("midrst_wait");
    wait_clk(30);
    m_acc = 10'h155;
    m_cnt = 1;
    check("midrst_hex2", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hex_of(m_acc)});
    check("midrst_led", {22'h0, LEDR}, {22'h0, 10'h101});
    KEY[0] = 1'b1;
    wait_clk(30);

    do_reset();
    set_sw(1023);
    press(1'b1, 1'b0, 25);
    for (int i = 0; i < 64; i++) press(1'b0, 1'b1, 25);
    check("wrap_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h30, 7'h03, 7'h0E});
    check("wrap_cnt", {24'h0, LEDR[7:0]}, 32'd65);
    check_model("wrap");

    for (int i = 0; i < 25; i++) begin
      set_sw(int'($urandom_range(0, 1023)));
      op = int'($urandom_range(0, 3));
      hold = int'($urandom_range(20, 60));
      case (op)
        0: press(1'b1, 1'b0, hold);
        1: press(1'b0, 1'b1, hold);
        2: press(1'b1, 1'b1, hold);
        default: press($urandom_range(0, 1) == 0, 1'b1, int'($urandom_range(1, 12)));
      endcase
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
